// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and sizing helpers for the keypad matrix scanner.
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} db_state_e;
  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_e;
  function automatic int code_width(input int rows, input int cols);
    int w;
    w = $clog2(rows * cols);
    return w < 1 ? 1 : w;
  endfunction
endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo: small key-code queue with sticky overflow on dropped pushes.
module keypad_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  input  logic         clr_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         ovf_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic ovf_q, empty, full, do_pop, do_push, drop;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i && !empty;
  // A pop on the same edge frees a slot, so a push while full still lands
  assign do_push = push_i && (!full || do_pop);
  assign drop    = push_i && full && !do_pop;
  assign data_o  = empty ? '0 : mem_q[rd_q];
  assign valid_o = !empty;
  assign ovf_o   = ovf_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      ovf_q <= drop ? 1'b1 : clr_i ? 1'b0 : ovf_q;
    end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row-scanned key matrix with frame-level debounce
// and a queued key-code output.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DWELL      = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [COLS-1:0]                     columnas,
  output logic [ROWS-1:0]                     filas,
  output logic [code_width(ROWS, COLS)-1:0]   key_code,
  output logic                                key_valid,
  input  logic                                key_ready,
  output logic                                key_held,
  output logic                                overflow,
  input  logic                                ovf_clear
);
  localparam int CW = code_width(ROWS, COLS);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(DWELL);
  localparam int NW = $clog2(DEBOUNCE + 1);
  logic [COLS-1:0] sync1_q, sync2_q;
  logic [RW-1:0] row_q;
  logic [DW-1:0] dwell_q;
  logic [1:0] acc_n_q, row_n, tot_n;
  logic [2:0] sum_n;
  logic [CW-1:0] acc_code_q, row_code, tot_code, code_q;
  logic row_end, frame_end, push_q, held_q;
  logic [NW-1:0] cnt_q;
  db_state_e state_q;
  frame_e frame;
  assign row_end   = dwell_q == DW'(DWELL - 1);
  assign frame_end = row_end && row_q == RW'(ROWS - 1);
  assign filas     = ROWS'(1) << row_q;
  assign key_held  = held_q;
  // Bit counts saturate at 2: only none/one/many matters for classification
  always_comb begin
    row_n    = '0;
    row_code = '0;
    for (int c = 0; c < COLS; c++)
      if (sync2_q[c]) begin
        row_n    = row_n == 2'd0 ? 2'd1 : 2'd2;
        row_code = CW'(int'(row_q) * COLS + c);
      end
    sum_n    = {1'b0, acc_n_q} + {1'b0, row_n};
    tot_n    = sum_n > 3'd1 ? 2'd2 : sum_n[1:0];
    tot_code = row_n != 2'd0 ? row_code : acc_code_q;
    frame    = tot_n == 2'd0 ? FR_NONE : tot_n == 2'd1 ? FR_SINGLE : FR_MULTI;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      row_q      <= '0;
      dwell_q    <= '0;
      acc_n_q    <= '0;
      acc_code_q <= '0;
    end else begin
      sync1_q <= columnas;
      sync2_q <= sync1_q;
      dwell_q <= row_end ? '0 : dwell_q + 1'b1;
      if (row_end) begin
        row_q      <= row_q == RW'(ROWS - 1) ? '0 : row_q + 1'b1;
        acc_n_q    <= frame_end ? '0 : tot_n;
        acc_code_q <= frame_end ? '0 : tot_code;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      push_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (frame_end)
        case (state_q)
          IDLE:
            if (frame == FR_SINGLE) begin
              code_q <= tot_code;
              if (DEBOUNCE == 1) begin
                push_q  <= 1'b1;
                held_q  <= 1'b1;
                state_q <= HELD;
                cnt_q   <= '0;
              end else begin
                state_q <= PRESS_DB;
                cnt_q   <= NW'(1);
              end
            end
          PRESS_DB:
            if (frame == FR_SINGLE && tot_code == code_q) begin
              if (cnt_q == NW'(DEBOUNCE - 1)) begin
                push_q  <= 1'b1;
                held_q  <= 1'b1;
                state_q <= HELD;
                cnt_q   <= '0;
              end else cnt_q <= cnt_q + 1'b1;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          HELD:
            if (frame == FR_NONE) begin
              if (DEBOUNCE == 1) begin
                held_q  <= 1'b0;
                state_q <= IDLE;
                cnt_q   <= '0;
              end else begin
                state_q <= RELEASE_DB;
                cnt_q   <= NW'(1);
              end
            end
          RELEASE_DB:
            if (frame == FR_NONE) begin
              if (cnt_q == NW'(DEBOUNCE - 1)) begin
                held_q  <= 1'b0;
                state_q <= IDLE;
                cnt_q   <= '0;
              end else cnt_q <= cnt_q + 1'b1;
            end else begin
              state_q <= HELD;
              cnt_q   <= '0;
            end
          default: state_q <= IDLE;
        endcase
    end
  keypad_fifo #(.W(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_q),
    .data_i (code_q),
    .pop_i  (key_ready),
    .clr_i  (ovf_clear),
    .data_o (key_code),
    .valid_o(key_valid),
    .ovf_o  (overflow)
  );
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed checks of scanning, debounce, queueing
// and overflow against a modelled 4x4 key matrix.
module tb_keypad_matrix_scanner;
  logic clk, rst, key_valid, key_ready, key_held, overflow, ovf_clear;
  logic [3:0] columnas, filas, key_code;
  logic [15:0] keys;
  int checks = 0, errors = 0, cyc = 0, first_v = -1, c0 = 0;
  bit held_seen = 0;
  keypad_matrix_scanner #(
    .ROWS(4), .COLS(4), .DWELL(4), .DEBOUNCE(3), .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .columnas (columnas),
    .filas    (filas),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .overflow (overflow),
    .ovf_clear(ovf_clear)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // A pressed key connects its column to its row only while that row is driven
  always_comb begin
    columnas = '0;
    for (int r = 0; r < 4; r++)
      if (filas[r]) columnas |= keys[r*4 +: 4];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (key_valid && first_v < 0) first_v = cyc;
      if (key_held) held_seen = 1;
    end
  endtask
  task automatic align();
    while (cyc % 16 != 0) step(1);
  endtask
  task automatic pop();
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
  endtask
  initial begin
    rst = 1'b0; keys = '0; key_ready = 1'b0; ovf_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_filas", filas, 1);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_code", key_code, 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("scan_filas", filas, 32'd1 << ((i / 4) % 4));
      step(1);
    end
    first_v = -1;
    step(160);
    chk("idle_no_valid", first_v, -1);
    // single press of key 6 (row 1, col 2), held for 5 frames
    c0 = cyc; first_v = -1; held_seen = 0;
    keys = 16'h0040;
    step(80);
    chk("press_latency", first_v - c0, 49);
    chk("press_code", key_code, 6);
    chk("press_held", key_held, 1);
    keys = '0;
    pop();
    chk("pop_empty", key_valid, 0);
    first_v = -1;
    align();
    step(64);
    chk("release_held", key_held, 0);
    chk("one_push", first_v, -1);
    // two-frame presses broken by one-frame releases
    first_v = -1; held_seen = 0;
    repeat (3) begin
      keys = 16'h0040;
      step(32);
      keys = '0;
      step(16);
    end
    chk("glitch_no_push", first_v, -1);
    chk("glitch_no_held", held_seen, 0);
    // keys 6 and 9 together, then 9 released
    first_v = -1;
    keys = 16'h0240;
    step(48);
    chk("multi_no_push", first_v, -1);
    keys = 16'h0040; c0 = cyc;
    step(64);
    chk("multi_rel_latency", first_v - c0, 49);
    chk("multi_rel_code", key_code, 6);
    keys = '0;
    pop();
    align();
    step(64);
    // three presses with the consumer stalled
    keys = 16'h0001; step(48); keys = '0; step(48);
    keys = 16'h0020; step(48); keys = '0; step(48);
    chk("full_no_ovf", overflow, 0);
    keys = 16'h0400; step(48); keys = '0; step(48);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", key_code, 0);
    pop();
    chk("ovf_second", key_code, 5);
    ovf_clear = 1'b1;
    step(1);
    ovf_clear = 1'b0;
    chk("ovf_cleared", overflow, 0);
    pop();
    chk("ovf_drained", key_valid, 0);
    align();
    // reset during PRESS_DB with one queued code
    keys = 16'h0008; step(48); keys = '0; step(48);
    chk("pre_rst_code", key_code, 3);
    keys = 16'h1000;
    step(21);
    rst = 1'b0;
    #1;
    chk("mid_rst_filas", filas, 1);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_ovf", overflow, 0);
    keys = '0;
    @(negedge clk);
    rst = 1'b1; cyc = 0; first_v = -1;
    step(64);
    chk("no_stale_code", first_v, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised successor to the fixed 4x4 keypad scanner in `system`. It drives the `filas` rows one at a time and samples the `columnas` inputs. Each single-key press is debounced over whole scan frames and queued as a key code in a small FIFO. Consumers (CPU GPIO bridge, 7-segment driver) read codes through a valid/ready handshake. An `overflow` flag reports lost presses.

## Interface
Parameters:
- `ROWS`, 4, number of row lines driven.
- `COLS`, 4, number of column lines sampled.
- `DWELL`, 50000, clock cycles each row stays driven. Minimum 3.
- `DEBOUNCE`, 4, consecutive identical frames needed to accept a press or a release. Minimum 1.
- `FIFO_DEPTH`, 4, queued key codes. Power of two, at least 2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `columnas`  in  COLS  raw column lines, active-high, asynchronous.
- `filas`  out  ROWS  one-hot row drive, active-high.
- `key_code`  out  CW  head-of-FIFO code, row*COLS+col. CW = max(1, clog2(ROWS*COLS)).
- `key_valid`  out  1  FIFO non-empty.
- `key_ready`  in  1  consumer accepts `key_code` when high with `key_valid`.
- `key_held`  out  1  a debounced key is currently held.
- `overflow`  out  1  sticky; a press was dropped because the FIFO was full.
- `ovf_clear`  in  1  one-cycle pulse; clears `overflow`.

## Operation
- `columnas` passes through a 2-flop synchronizer before any use.
- A row counter advances `filas` one-hot. Sequence: row 0, row 1, …, row ROWS-1, then wrap to row 0.
- The synchronized columns are sampled on the last cycle of each row's dwell.
- Frame evaluation happens at the end of the dwell of row ROWS-1. The frame is classified as:
  - NONE: no bits set.
  - SINGLE(code): exactly one bit set over the whole frame.
  - MULTI: more than one bit set.
- Debounce FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. The debounce counter resets on every state change.
  - IDLE: SINGLE(c) → latch c, count=1, go to PRESS_DB. If DEBOUNCE=1, push immediately and go to HELD.
  - PRESS_DB: SINGLE(latched c) → count+1. When count reaches DEBOUNCE, push c and go to HELD. Any other frame → IDLE.
  - HELD: NONE → RELEASE_DB, count=1. SINGLE(same c) → stay. MULTI or a different code → stay; no push, no change to the latched code.
  - RELEASE_DB: NONE → count+1. When count reaches DEBOUNCE → IDLE. Any other frame → HELD.
- One press produces exactly one push. Auto-repeat is not provided.
- `key_held` is high in HELD and RELEASE_DB.
- FIFO:
  - A push while full is dropped and sets `overflow`.
  - Push and pop in the same cycle while full: the pop happens and the push is accepted.
  - Push and pop in the same cycle while empty: no bypass; the pushed code becomes visible the next cycle.
  - `ovf_clear` coinciding with an overflow event leaves `overflow` set; set wins.

## Timing
- Reset values:
  - `filas` = row 0 driven (value 1).
  - `key_valid`, `key_held`, `overflow` = 0; `key_code` = 0.
  - FSM in IDLE; counters and FIFO empty.
- Frame length is ROWS*DWELL cycles.
- Column latency from pin to sample is 2 cycles, so a row's sample reflects its own drive whenever DWELL ≥ 3.
- Minimum latency from the start of the first pressed frame to the push is DEBOUNCE frames. `key_valid` rises 1 cycle after the push edge.
- A pop occurs on any edge with `key_valid` && `key_ready`. The next code, or `key_valid`=0, is visible the following cycle.
- Reset asserted mid-scan or mid-debounce returns all state to the reset values immediately; queued codes are lost.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state enum;
  - the frame-class encoding (NONE/SINGLE/MULTI);
  - a code-width function CW(ROWS, COLS).
- Sub-module `keypad_fifo` (width CW, depth FIFO_DEPTH) covers push/pop, full/empty and overflow detection.
- The top level keeps the synchronizer, scan counter, frame classifier and debounce FSM.

## Test plan
Bench settings: DWELL=4, ROWS=COLS=4, DEBOUNCE=3, FIFO_DEPTH=2. The bench models the key matrix: `columnas` bit c is high only while `filas` drives the pressed key's row.
- Reset, no keys → `filas` cycles 1,2,4,8 every 4 cycles; `key_valid` stays 0 for 10 frames.
- Press key row1/col2 for 5 frames → one code 6 with `key_valid` after 3 frames; `key_held`=1; `ready`=1 pops it.
- Key with 1-frame glitches (press 2 frames, release 1, repeat) → no push, state returns to IDLE.
- Keys 6 and 9 held together → MULTI frames, no push. Release 9 only → code 6 pushed after 3 frames.
- `ready`=0; three distinct presses, each released for 3 frames → codes 0, 5 queued, third dropped, `overflow`=1. `ovf_clear` → `overflow`=0.
- Reset pulsed mid-PRESS_DB and with the FIFO holding 1 code → all outputs back to reset values; no stale code appears.
